// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
// Paces the DA2 serial DAC converter: a sample-period timer issues one tick
// per period, each serviced tick pops a sample pair from a small FIFO and
// fires a one-cycle START, and the block then waits for DONE. An empty FIFO
// repeats the last sample (underrun). A tick during a transfer is dropped
// (late). Both events are counted in saturating counters.
module dac_sample_scheduler #(
  parameter int DATA_W = 12,
  parameter int DIV_W  = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           period,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data1,
  input  logic [DATA_W-1:0]          s_data2,
  output logic                       dac_start,
  output logic [DATA_W-1:0]          dac_data1,
  output logic [DATA_W-1:0]          dac_data2,
  input  logic                       dac_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                underrun_cnt,
  output logic [15:0]                late_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [DATA_W-1:0]   mem1_r [DEPTH];
  logic [DATA_W-1:0]   mem2_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       count_r;
  logic                empty_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;

  logic [DIV_W-1:0]    period_eff_s;
  logic [DIV_W-1:0]    timer_r;
  logic [DIV_W-1:0]    timer_s;
  logic                load_pend_r;
  logic                tick_s;

  logic                underrun_inc_s;
  logic                late_inc_s;

  logic                dac_start_r;
  logic                busy_r;
  logic [DATA_W-1:0]   dac_data1_r;
  logic [DATA_W-1:0]   dac_data2_r;
  logic [15:0]         underrun_cnt_r;
  logic [15:0]         late_cnt_r;

  // Saturating increment for the fault counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  assign empty_s      = (count_r == LW'(0));
  assign full_s       = (count_r == LW'(DEPTH));
  // s_ready depends only on the registered occupancy, so a pop in the same
  // cycle never opens the door for a push into a full FIFO.
  assign push_s       = s_valid && !full_s;
  assign period_eff_s = (period < DIV_W'(2)) ? DIV_W'(2) : period;

  // Effective timer value: while a reload is pending (after reset or while
  // disabled) the timer reads as period_eff-1, tracking the live period.
  always_comb begin
    timer_s = timer_r;
    tick_s  = 1'b0;
    if (load_pend_r) begin
      timer_s = period_eff_s - DIV_W'(1);
    end else begin
      timer_s = timer_r;
    end
    if (enable && !load_pend_r && (timer_r == DIV_W'(0))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Sample-period down-counter with reload on each tick.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      timer_r     <= DIV_W'(0);
      load_pend_r <= 1'b1;
    end else if (!enable) begin
      timer_r     <= timer_r;
      load_pend_r <= 1'b1;
    end else if (tick_s) begin
      timer_r     <= period_eff_s - DIV_W'(1);
      load_pend_r <= 1'b0;
    end else begin
      timer_r     <= timer_s - DIV_W'(1);
      load_pend_r <= 1'b0;
    end
  end

  // Next-state logic, FIFO pop and fault-counter increments.
  always_comb begin
    state_next_s   = state_r;
    pop_s          = 1'b0;
    underrun_inc_s = 1'b0;
    late_inc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_next_s = ST_ISSUE;
          if (!empty_s) begin
            pop_s = 1'b1;
          end else begin
            underrun_inc_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // DONE cannot legitimately arrive in the START cycle; ignore it.
        state_next_s = ST_WAIT;
        late_inc_s   = tick_s;
      end
      ST_WAIT: begin
        late_inc_s = tick_s;
        if (dac_done) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered START/busy outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      dac_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      dac_start_r <= (state_next_s == ST_ISSUE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem1_r[wr_ptr_r] <= s_data1;
      mem2_r[wr_ptr_r] <= s_data2;
    end else begin
      mem1_r[wr_ptr_r] <= mem1_r[wr_ptr_r];
      mem2_r[wr_ptr_r] <= mem2_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= LW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // DAC data holding registers: load on pop, otherwise repeat last sample.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      dac_data1_r <= DATA_W'(0);
      dac_data2_r <= DATA_W'(0);
    end else if (pop_s) begin
      dac_data1_r <= mem1_r[rd_ptr_r];
      dac_data2_r <= mem2_r[rd_ptr_r];
    end else begin
      dac_data1_r <= dac_data1_r;
      dac_data2_r <= dac_data2_r;
    end
  end

  // Saturating underrun and late-tick counters.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      underrun_cnt_r <= 16'd0;
      late_cnt_r     <= 16'd0;
    end else begin
      if (underrun_inc_s) begin
        underrun_cnt_r <= sat_inc(underrun_cnt_r);
      end
      if (late_inc_s) begin
        late_cnt_r <= sat_inc(late_cnt_r);
      end
    end
  end

  assign s_ready      = !full_s;
  assign fifo_level   = count_r;
  assign dac_start    = dac_start_r;
  assign busy         = busy_r;
  assign dac_data1    = dac_data1_r;
  assign dac_data2    = dac_data2_r;
  assign underrun_cnt = underrun_cnt_r;
  assign late_cnt     = late_cnt_r;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Testbench for dac_sample_scheduler: scenario tasks against a transaction-
// level model (sample queue, tick phase, busy flag) plus a converter model
// that answers each START with DONE a programmable number of cycles later.
module tb_dac_sample_scheduler;

  localparam int DW  = 12;
  localparam int DIV = 16;
  localparam int DEP = 8;

  logic            clk_in = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [DIV-1:0]  period = 16'd16;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data1 = 12'd0;
  logic [DW-1:0]   s_data2 = 12'd0;
  logic            dac_start;
  logic [DW-1:0]   dac_data1;
  logic [DW-1:0]   dac_data2;
  logic            dac_done = 1'b0;
  logic            busy;
  logic [3:0]      fifo_level;
  logic [15:0]     underrun_cnt;
  logic [15:0]     late_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [DW-1:0] mq1[$], mq2[$];   // expected FIFO contents
  logic [DW-1:0] pq1[$], pq2[$];   // upstream pairs waiting to be offered
  logic [DW-1:0] m_last1, m_last2;
  int  m_under, m_late;
  bit  m_busy, m_issue, m_start;
  int  m_phase, m_p;
  int  dcnt, dly, cyc;

  dac_sample_scheduler #(.DATA_W(DW), .DIV_W(DIV), .DEPTH(DEP)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .period(period),
    .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
    .dac_start(dac_start), .dac_data1(dac_data1), .dac_data2(dac_data2),
    .dac_done(dac_done), .busy(busy), .fifo_level(fifo_level),
    .underrun_cnt(underrun_cnt), .late_cnt(late_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic m_reset();
    mq1.delete(); mq2.delete(); pq1.delete(); pq2.delete();
    m_last1 = 12'd0; m_last2 = 12'd0;
    m_under = 0; m_late = 0;
    m_busy = 1'b0; m_issue = 1'b0; m_start = 1'b0;
    m_phase = 0; m_p = 2; dcnt = 0; cyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; s_valid = 1'b0; dac_done = 1'b0;
    m_reset();
    #17;
    rst = 1'b1;
    @(posedge clk_in); #1;
  endtask

  // One clock: offer upstream data, advance the model, clock the DUT,
  // then let the converter model react.
  task automatic step();
    bit tick, push, done_ok;
    int p_eff;
    s_valid = (pq1.size() > 0);
    if (s_valid) begin
      s_data1 = pq1[0]; s_data2 = pq2[0];
    end else begin
      s_data1 = DW'($urandom); s_data2 = DW'($urandom);
    end
    p_eff = (period < 16'd2) ? 2 : int'(period);
    tick = 1'b0;
    if (!enable) begin
      m_phase = 0;
    end else begin
      if (m_phase == 0) m_p = p_eff;
      m_phase++;
      if (m_phase == m_p) begin
        tick = 1'b1;
        m_phase = 0;
      end
    end
    push = s_valid && (mq1.size() < DEP);
    done_ok = m_busy && !m_issue && dac_done;
    m_start = 1'b0;
    if (tick) begin
      if (m_busy) begin
        if (m_late < 65535) m_late++;
      end else begin
        m_start = 1'b1;
        if (mq1.size() > 0) begin
          m_last1 = mq1.pop_front(); m_last2 = mq2.pop_front();
        end else if (m_under < 65535) begin
          m_under++;
        end
      end
    end
    if (done_ok) m_busy = 1'b0;
    if (m_start) m_busy = 1'b1;
    m_issue = m_start;
    if (push) begin
      mq1.push_back(s_data1); mq2.push_back(s_data2);
      void'(pq1.pop_front()); void'(pq2.pop_front());
    end
    @(posedge clk_in); #1;
    cyc++;
    dac_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) dac_done = 1'b1;
    end
    if (m_start) dcnt = dly;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; s_valid = 1'b0; dac_done = 1'b0;
    m_reset();
    #17;
    rst = 1'b1;
    @(posedge clk_in); #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_cmp++; if (dac_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%0b exp=0", dac_start); end
    n_cmp++; if ({dac_data1, dac_data2} !== 24'd0) begin n_bad++; $display("FAIL reset_data got=%h/%h exp=0/0", dac_data1, dac_data2); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (underrun_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt); end
    n_cmp++; if (late_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_late got=%0d exp=0", late_cnt); end
    period = 16'd2;
    repeat (6) begin
      step();
      n_cmp++; if (dac_start !== 1'b0) begin n_bad++; $display("FAIL reset_idle_start cyc=%0d got=%0b exp=0", cyc, dac_start); end
    end
  endtask

  task automatic test_nominal();
    int prev, nst;
    do_reset();
    period = 16'd16; dly = 4;
    pq1.push_back(12'h100); pq2.push_back(12'h200);
    pq1.push_back(12'h300); pq2.push_back(12'h400);
    enable = 1'b1;
    prev = -1; nst = 0;
    repeat (40) begin
      step();
      n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL nominal_start cyc=%0d got=%0b exp=%0b", cyc, dac_start, m_start); end
      if (m_start) begin
        nst++;
        n_cmp++;
        if ({dac_data1, dac_data2} !== {m_last1, m_last2}) begin n_bad++; $display("FAIL nominal_data cyc=%0d got=%h/%h exp=%h/%h", cyc, dac_data1, dac_data2, m_last1, m_last2); end
        if (prev >= 0) begin
          n_cmp++; if (cyc - prev != 16) begin n_bad++; $display("FAIL nominal_spacing got=%0d exp=16", cyc - prev); end
        end
        prev = cyc;
      end
    end
    n_cmp++; if (nst != 2) begin n_bad++; $display("FAIL nominal_count got=%0d exp=2", nst); end
    n_cmp++; if ({dac_data1, dac_data2} !== 24'h300400) begin n_bad++; $display("FAIL nominal_last got=%h/%h exp=300/400", dac_data1, dac_data2); end
    n_cmp++; if (underrun_cnt !== 16'd0) begin n_bad++; $display("FAIL nominal_underrun got=%0d exp=0", underrun_cnt); end
  endtask

  task automatic test_underrun();
    int nst, guard;
    do_reset();
    period = 16'd5; dly = 2;
    pq1.push_back(12'hABC); pq2.push_back(12'h123);
    enable = 1'b1;
    nst = 0; guard = 0;
    while (nst < 3 && guard < 60) begin
      step();
      guard++;
      n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL underrun_start cyc=%0d got=%0b exp=%0b", cyc, dac_start, m_start); end
      if (m_start) begin
        nst++;
        n_cmp++; if ({dac_data1, dac_data2} !== 24'hABC123) begin n_bad++; $display("FAIL underrun_data got=%h/%h exp=abc/123", dac_data1, dac_data2); end
      end
    end
    n_cmp++; if (nst != 3) begin n_bad++; $display("FAIL underrun_timeout starts=%0d exp=3", nst); end
    n_cmp++; if (underrun_cnt !== 16'd2) begin n_bad++; $display("FAIL underrun_cnt got=%0d exp=2", underrun_cnt); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL underrun_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_late();
    int nst, guard;
    do_reset();
    period = 16'd4; dly = 10;
    enable = 1'b1;
    nst = 0; guard = 0;
    while (nst < 3 && guard < 80) begin
      step();
      guard++;
      n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL late_start cyc=%0d got=%0b exp=%0b", cyc, dac_start, m_start); end
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL late_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy); end
      if (m_start) begin
        // two ticks fall inside each 11-cycle transfer at period 4
        n_cmp++; if (late_cnt !== 16'(2 * nst)) begin n_bad++; $display("FAIL late_cnt got=%0d exp=%0d", late_cnt, 2 * nst); end
        nst++;
      end
    end
    n_cmp++; if (nst != 3) begin n_bad++; $display("FAIL late_timeout starts=%0d exp=3", nst); end
  endtask

  task automatic test_full();
    do_reset();
    period = 16'd4; dly = 1;
    for (int i = 0; i < 9; i++) begin
      pq1.push_back(DW'($urandom)); pq2.push_back(DW'($urandom));
    end
    repeat (10) step();
    n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%0b exp=0", s_ready); end
    enable = 1'b1;
    repeat (50) begin
      step();
      n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL full_start cyc=%0d got=%0b exp=%0b", cyc, dac_start, m_start); end
      n_cmp++; if (fifo_level !== 4'(mq1.size())) begin n_bad++; $display("FAIL full_level_run cyc=%0d got=%0d exp=%0d", cyc, fifo_level, mq1.size()); end
      if (m_start) begin
        n_cmp++; if ({dac_data1, dac_data2} !== {m_last1, m_last2}) begin n_bad++; $display("FAIL full_data cyc=%0d got=%h/%h exp=%h/%h", cyc, dac_data1, dac_data2, m_last1, m_last2); end
      end
    end
    n_cmp++; if (underrun_cnt !== 16'(m_under)) begin n_bad++; $display("FAIL full_underrun got=%0d exp=%0d", underrun_cnt, m_under); end
  endtask

  task automatic test_clamp_reset();
    int prev, guard;
    do_reset();
    period = 16'($urandom_range(0, 1)); dly = 1;
    for (int i = 0; i < 6; i++) begin
      pq1.push_back(DW'($urandom)); pq2.push_back(DW'($urandom));
    end
    enable = 1'b1;
    prev = -1;
    repeat (24) begin
      step();
      n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL clamp_start cyc=%0d got=%0b exp=%0b", cyc, dac_start, m_start); end
      if (m_start) begin
        n_cmp++; if ({dac_data1, dac_data2} !== {m_last1, m_last2}) begin n_bad++; $display("FAIL clamp_data got=%h/%h exp=%h/%h", dac_data1, dac_data2, m_last1, m_last2); end
        // DONE is only honoured in WAIT, so the tick two cycles after a
        // start coincides with DONE and is dropped: starts land every 4.
        if (prev >= 0) begin
          n_cmp++; if (cyc - prev != 4) begin n_bad++; $display("FAIL clamp_spacing got=%0d exp=4", cyc - prev); end
        end
        prev = cyc;
      end
    end
    n_cmp++; if (late_cnt !== 16'(m_late)) begin n_bad++; $display("FAIL clamp_late got=%0d exp=%0d", late_cnt, m_late); end
    // reset during WAIT
    guard = 0;
    while (!(m_busy && !m_issue) && guard < 20) begin step(); guard++; end
    n_cmp++; if (!(m_busy && !m_issue)) begin n_bad++; $display("FAIL wait_timeout got=idle exp=wait"); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstwait_busy got=%0b exp=0", busy); end
    n_cmp++; if (dac_start !== 1'b0) begin n_bad++; $display("FAIL rstwait_start got=%0b exp=0", dac_start); end
    n_cmp++; if ({underrun_cnt, late_cnt} !== 32'd0) begin n_bad++; $display("FAIL rstwait_cnt got=%0d/%0d exp=0/0", underrun_cnt, late_cnt); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL rstwait_level got=%0d exp=0", fifo_level); end
    // reset during the START cycle drops it without a clock edge
    do_reset();
    period = 16'd0; dly = 1; enable = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!m_start && guard < 10);
    n_cmp++; if (dac_start !== 1'b1) begin n_bad++; $display("FAIL issue_start got=%0b exp=1", dac_start); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (dac_start !== 1'b0) begin n_bad++; $display("FAIL rstissue_start got=%0b exp=0", dac_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstissue_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      period = 16'($urandom_range(0, 9)); dly = $urandom_range(1, 12);
      enable = 1'b1;
      repeat (200) begin
        if (pq1.size() < 3 && $urandom_range(0, 2) == 0) begin
          pq1.push_back(DW'($urandom)); pq2.push_back(DW'($urandom));
        end
        if ($urandom_range(0, 29) == 0) enable = ~enable;
        step();
        n_cmp++; if (dac_start !== m_start) begin n_bad++; $display("FAIL rand_start r=%0d cyc=%0d got=%0b exp=%0b", r, cyc, dac_start, m_start); end
        n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rand_busy r=%0d cyc=%0d got=%0b exp=%0b", r, cyc, busy, m_busy); end
        n_cmp++; if (fifo_level !== 4'(mq1.size())) begin n_bad++; $display("FAIL rand_level r=%0d cyc=%0d got=%0d exp=%0d", r, cyc, fifo_level, mq1.size()); end
        if (m_start) begin
          n_cmp++; if ({dac_data1, dac_data2} !== {m_last1, m_last2}) begin n_bad++; $display("FAIL rand_data r=%0d cyc=%0d got=%h/%h exp=%h/%h", r, cyc, dac_data1, dac_data2, m_last1, m_last2); end
        end
      end
      n_cmp++; if (underrun_cnt !== 16'(m_under)) begin n_bad++; $display("FAIL rand_underrun r=%0d got=%0d exp=%0d", r, underrun_cnt, m_under); end
      n_cmp++; if (late_cnt !== 16'(m_late)) begin n_bad++; $display("FAIL rand_late r=%0d got=%0d exp=%0d", r, late_cnt, m_late); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_late();
    test_full();
    test_clamp_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
